// File: rtl/fifo_mac_reader_if.sv
// Operand FIFO read ports, start/busy control and the result handshake of fifo_mac_reader.
// The master side is the MAC engine; the slave side is the FIFOs and result consumer.
interface fifo_mac_reader_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 24
);
  logic                  i_start;
  logic                  o_busy;
  logic                  i_a_empty;
  logic [DATA_WIDTH-1:0] i_a_data;
  logic                  o_a_rden;
  logic                  i_b_empty;
  logic [DATA_WIDTH-1:0] i_b_data;
  logic                  o_b_rden;
  logic                  o_res_valid;
  logic                  i_res_ready;
  logic [ACC_WIDTH-1:0]  o_result;

  modport master (
    input  i_start, i_a_empty, i_a_data, i_b_empty, i_b_data, i_res_ready,
    output o_busy, o_a_rden, o_b_rden, o_res_valid, o_result
  );

  modport slave (
    output i_start, i_a_empty, i_a_data, i_b_empty, i_b_data, i_res_ready,
    input  o_busy, o_a_rden, o_b_rden, o_res_valid, o_result
  );
endinterface

// File: rtl/fifo_mac_reader.sv
// Drains COUNT operand pairs from FIFOs A and B and accumulates their signed dot product,
// then offers the sum on a valid/ready handshake.
//
// state  | meaning
// S_IDLE | waiting for start; result holds the previous sum
// S_RUN  | issuing paired reads and accumulating returned operands
// S_DONE | result valid, waiting for res_ready
module fifo_mac_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 24,
  parameter int COUNT      = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  fifo_mac_reader_if.master   bus
);
  localparam int CW = $clog2(COUNT + 1);
  localparam logic [CW-1:0] COUNT_C  = CW'(COUNT);
  localparam logic [CW-1:0] COUNT_M1 = CW'(COUNT - 1);
  localparam int PW = 2 * DATA_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CW-1:0]         r_issued;
  logic [CW-1:0]         r_received;
  logic                  r_rd_pend;
  logic [ACC_WIDTH-1:0]  r_acc;
  logic                  w_rden;
  logic                  w_start_run;
  logic signed [PW-1:0]  w_a_ext;
  logic signed [PW-1:0]  w_b_ext;
  logic signed [PW-1:0]  w_prod;
  logic [ACC_WIDTH-1:0]  w_prod_ext;

  // Both FIFOs are read together so an operand pair can never be split.
  assign w_rden      = (r_state == S_RUN) && !bus.i_a_empty && !bus.i_b_empty
                       && (r_issued < COUNT_C);
  assign w_start_run = (r_state == S_IDLE) && bus.i_start;

  assign w_a_ext    = PW'($signed(bus.i_a_data));
  assign w_b_ext    = PW'($signed(bus.i_b_data));
  assign w_prod     = w_a_ext * w_b_ext;
  assign w_prod_ext = ACC_WIDTH'(w_prod);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.i_start) w_state_nxt = S_RUN;
      S_RUN:   if (r_rd_pend && (r_received == COUNT_M1)) w_state_nxt = S_DONE;
      S_DONE:  if (bus.i_res_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_issued   <= '0;
      r_received <= '0;
      r_rd_pend  <= 1'b0;
      r_acc      <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start_run) begin
        r_issued   <= '0;
        r_received <= '0;
        r_rd_pend  <= 1'b0;
        r_acc      <= '0;
      end else begin
        r_rd_pend <= w_rden;
        if (w_rden) r_issued <= r_issued + 1'b1;
        // Data from the previous edge's read is on the FIFO outputs now.
        if (r_rd_pend) begin
          r_acc      <= r_acc + w_prod_ext;
          r_received <= r_received + 1'b1;
        end
      end
    end
  end

  assign bus.o_a_rden    = w_rden;
  assign bus.o_b_rden    = w_rden;
  assign bus.o_busy      = (r_state != S_IDLE);
  assign bus.o_res_valid = (r_state == S_DONE);
  assign bus.o_result    = r_acc;
endmodule

// File: tb/tb_fifo_mac_reader.sv
// Directed bench for fifo_mac_reader: two instances (24- and 16-bit accumulators) share one
// pair of FIFO models and are checked every cycle against a pair-level dot-product model.
module tb_fifo_mac_reader;
  localparam int DW    = 8;
  localparam int COUNT = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          start = 1'b0;
  logic          res_ready = 1'b1;
  logic          a_empty = 1'b1;
  logic          b_empty = 1'b1;
  logic [DW-1:0] a_data = '0;
  logic [DW-1:0] b_data = '0;

  fifo_mac_reader_if #(.DATA_WIDTH(DW), .ACC_WIDTH(24)) bus24();
  fifo_mac_reader_if #(.DATA_WIDTH(DW), .ACC_WIDTH(16)) bus16();

  assign bus24.i_start = start;     assign bus16.i_start = start;
  assign bus24.i_a_empty = a_empty; assign bus16.i_a_empty = a_empty;
  assign bus24.i_b_empty = b_empty; assign bus16.i_b_empty = b_empty;
  assign bus24.i_a_data = a_data;   assign bus16.i_a_data = a_data;
  assign bus24.i_b_data = b_data;   assign bus16.i_b_data = b_data;
  assign bus24.i_res_ready = res_ready; assign bus16.i_res_ready = res_ready;

  fifo_mac_reader #(.DATA_WIDTH(DW), .ACC_WIDTH(24), .COUNT(COUNT)) u_dut24 (
    .clk(clk), .rst_n(rst_n), .bus(bus24));
  fifo_mac_reader #(.DATA_WIDTH(DW), .ACC_WIDTH(16), .COUNT(COUNT)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .bus(bus16));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // FIFO contents seen by the DUTs, and an independent copy for the model.
  logic [DW-1:0] qa[$];
  logic [DW-1:0] qb[$];
  int            ma[$];
  int            mb[$];
  bit            stall_en = 1'b0;

  task automatic push_pair(input int a, input int b);
    qa.push_back(DW'(a));
    qb.push_back(DW'(b));
    ma.push_back(a);
    mb.push_back(b);
  endtask

  // Synchronous FIFO models: registered empty, data one clock after an accepted read.
  int nb_reads = 0;
  int stall    = 0;
  initial begin
    logic rda, rdb, st;
    forever begin
      @(posedge clk);
      rda = bus24.o_a_rden;
      rdb = bus24.o_b_rden;
      st  = start;
      #1;
      if (st) nb_reads = 0;
      if (rda && qa.size() > 0) a_data = qa.pop_front();
      if (rdb && qb.size() > 0) begin
        b_data = qb.pop_front();
        nb_reads++;
      end
      if (stall_en && rdb && nb_reads == 2) stall = 3;
      else if (stall > 0) stall--;
      a_empty = (qa.size() == 0);
      b_empty = (qb.size() == 0) || (stall > 0);
    end
  end

  // Model: phase 0 idle, 1 running, 2 result offered. Popped pairs become products that
  // land in the sum one edge later.
  int     m_phase  = 0;
  int     m_issued = 0;
  int     m_got    = 0;
  longint m_sum    = 0;
  longint m_prod[$];

  function automatic bit exp_rden();
    return (m_phase == 1) && !a_empty && !b_empty && (m_issued < COUNT);
  endfunction

  initial begin
    bit rd;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_phase = 0; m_issued = 0; m_got = 0; m_sum = 0;
        m_prod.delete();
      end else begin
        rd = exp_rden();
        case (m_phase)
          0: if (start) begin
               m_phase = 1; m_issued = 0; m_got = 0; m_sum = 0;
               m_prod.delete();
             end
          1: begin
               if (m_prod.size() > 0) begin
                 m_sum += m_prod.pop_front();
                 m_got++;
               end
               if (rd) begin
                 m_prod.push_back(longint'(ma.pop_front() * mb.pop_front()));
                 m_issued++;
               end
               if (m_got == COUNT) m_phase = 2;
             end
          default: if (res_ready) m_phase = 0;
        endcase
      end
    end
  end

  initial begin
    bit e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        e = exp_rden();
        check("a_rden24", 64'(bus24.o_a_rden), 64'(e));
        check("b_rden24", 64'(bus24.o_b_rden), 64'(e));
        check("a_rden16", 64'(bus16.o_a_rden), 64'(e));
        check("b_rden16", 64'(bus16.o_b_rden), 64'(e));
        check("busy", 64'({bus24.o_busy, bus16.o_busy}), (m_phase != 0) ? 64'd3 : 64'd0);
        check("res_valid", 64'({bus24.o_res_valid, bus16.o_res_valid}),
              (m_phase == 2) ? 64'd3 : 64'd0);
        if (m_phase == 2) begin
          check("result24", 64'(bus24.o_result), m_sum & 64'hFFFFFF);
          check("result16", 64'(bus16.o_result), m_sum & 64'hFFFF);
        end
      end
    end
  end

  // Per-run observations, indexed by cycle relative to the start cycle.
  int     first_v, second_v;
  int     rmask, vmask, bmask;
  longint r24_a, r16_a, r24_b;
  bit     bp_mode = 1'b0;

  task automatic run(input bit hold_start, input bit ready_init, input int ncyc);
    bit prev_v = 1'b0;
    first_v = -1; second_v = -1;
    rmask = 0; vmask = 0; bmask = 0;
    r24_a = -1; r16_a = -1; r24_b = -1;
    @(posedge clk); #1;
    start = 1'b1;
    res_ready = ready_init;
    @(negedge clk);
    for (int cyc = 1; cyc <= ncyc; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 1 && !hold_start) start = 1'b0;
      if (hold_start && second_v >= 0) start = 1'b0;
      if (bp_mode) begin
        if (cyc == 8)  start = 1'b1;
        if (cyc == 9)  start = 1'b0;
        if (cyc == 11) res_ready = 1'b1;
      end
      @(negedge clk);
      if (bus24.o_a_rden) rmask |= (1 << cyc);
      if (bus24.o_busy)   bmask |= (1 << cyc);
      if (bus24.o_res_valid) begin
        vmask |= (1 << cyc);
        if (!prev_v) begin
          if (first_v < 0) begin
            first_v = cyc;
            r24_a = longint'(bus24.o_result);
            r16_a = longint'(bus16.o_result);
          end else if (second_v < 0) begin
            second_v = cyc;
            r24_b = longint'(bus24.o_result);
          end
        end
      end
      prev_v = bus24.o_res_valid;
    end
    start = 1'b0;
    res_ready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    check("reset_outputs24", 64'({bus24.o_a_rden, bus24.o_b_rden, bus24.o_busy,
          bus24.o_res_valid}), 64'd0);
    check("reset_result24", 64'(bus24.o_result), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Basic: 1*5 + 2*6 + 3*7 + 4*8 = 70
    @(negedge clk);
    for (int i = 0; i < 4; i++) push_pair(i + 1, i + 5);
    repeat (2) @(negedge clk);
    run(1'b0, 1'b1, 12);
    check("basic_rden_cycles", 64'(rmask), 64'h1E);
    check("basic_busy_cycles", 64'(bmask), 64'h7E);
    check("basic_valid_cycle", 64'(first_v), 64'd6);
    check("basic_result24", 64'(r24_a), 64'd70);
    check("basic_result16", 64'(r16_a), 64'd70);

    // Signed: 4 * (-1 * 2) = -8
    @(negedge clk);
    for (int i = 0; i < 4; i++) push_pair(-1, 2);
    repeat (2) @(negedge clk);
    run(1'b0, 1'b1, 12);
    check("signed_valid_cycle", 64'(first_v), 64'd6);
    check("signed_result24", 64'(r24_a), 64'hFFFFF8);
    check("signed_result16", 64'(r16_a), 64'hFFF8);

    // Stall: B empty for three cycles after the second read
    @(negedge clk);
    for (int i = 0; i < 4; i++) push_pair(i + 1, i + 5);
    stall_en = 1'b1;
    repeat (2) @(negedge clk);
    run(1'b0, 1'b1, 14);
    stall_en = 1'b0;
    check("stall_rden_cycles", 64'(rmask), 64'hC6);
    check("stall_valid_cycle", 64'(first_v), 64'd9);
    check("stall_result24", 64'(r24_a), 64'd70);

    // Backpressure and wrap: 4 * 16384 = 65536
    @(negedge clk);
    for (int i = 0; i < 4; i++) push_pair(-128, -128);
    bp_mode = 1'b1;
    repeat (2) @(negedge clk);
    run(1'b0, 1'b0, 20);
    bp_mode = 1'b0;
    check("bp_valid_cycle", 64'(first_v), 64'd6);
    check("bp_valid_hold", 64'(vmask), 64'hFC0);
    check("bp_busy_release", 64'((bmask >> 11) & 3), 64'd1);
    check("bp_start_ignored", 64'(second_v), 64'hFFFF_FFFF_FFFF_FFFF);
    check("wrap_result24", 64'(r24_a), 64'h10000);
    check("wrap_result16", 64'(r16_a), 64'h0);

    // Back-to-back: second run starts in the IDLE cycle after acceptance
    @(negedge clk);
    for (int i = 0; i < 4; i++) push_pair(i + 1, i + 5);
    push_pair(-3, 7); push_pair(4, -8); push_pair(-5, 9); push_pair(6, 10);
    repeat (2) @(negedge clk);
    run(1'b1, 1'b1, 20);
    check("b2b_first_cycle", 64'(first_v), 64'd6);
    check("b2b_second_cycle", 64'(second_v), 64'd13);
    check("b2b_rden_cycles", 64'(rmask), 64'hF1E);
    check("b2b_result_second", 64'(r24_b), 64'hFFFFDA);

    // Asynchronous reset in the middle of a run
    @(negedge clk);
    for (int i = 0; i < 4; i++) push_pair(i + 1, i + 5);
    repeat (2) @(negedge clk);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_ctrl", 64'({bus24.o_a_rden, bus24.o_b_rden, bus24.o_busy,
          bus24.o_res_valid, bus16.o_a_rden, bus16.o_busy}), 64'd0);
    check("async_rst_result", 64'({bus24.o_result, bus16.o_result}), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    qa.delete(); qb.delete(); ma.delete(); mb.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_idle", 64'({bus24.o_a_rden, bus24.o_busy}), 64'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fifo_mac_reader.md
# fifo_mac_reader

Consumer-side engine that drains paired operands from two synchronous FIFOs (A and B) and computes a signed multiply-accumulate over a fixed-length vector. It sits downstream of the operand FIFOs and drives their read enables according to the FIFO read protocol. That protocol: `rden` is honoured only when not empty, and `o_data` becomes valid one clock after the accepted read, then holds. The block presents the dot-product result on a valid/ready output handshake.

## Interface
- DATA_WIDTH, 8: width of each operand, two's complement signed.
- ACC_WIDTH, 24: accumulator/result width; must be ≥ 2*DATA_WIDTH.
- COUNT, 8: operand pairs per result; must be ≥ 1.
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  begin a new accumulation; sampled only in IDLE.
- a_empty  in  1  FIFO A empty flag (registered by FIFO).
- a_data  in  DATA_WIDTH  FIFO A read data.
- a_rden  out  1  FIFO A read enable.
- b_empty  in  1  FIFO B empty flag.
- b_data  in  DATA_WIDTH  FIFO B read data.
- b_rden  out  1  FIFO B read enable.
- busy  out  1  high in RUN and DONE.
- res_valid  out  1  result available.
- res_ready  in  1  downstream accepts result.
- result  out  ACC_WIDTH  accumulated dot product.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN when start=1: clear acc, issued, received and rd_pend.
  - RUN → DONE on the edge where received reaches COUNT.
  - DONE → IDLE on the edge where res_valid && res_ready.
- start is ignored in RUN and DONE. No restart/abort input exists.
- Read issue (combinational): a_rden = b_rden = (state==RUN) && !a_empty && !b_empty && (issued < COUNT).
  - Both enables are always identical, so the FIFOs are never read when empty and operand pairing is never broken.
- rd_pend: register that captures the rden value each edge.
- On an edge with rd_pend=1 (data valid from the previous read):
  - acc ← acc + sext(a_data) × sext(b_data).
  - received increments.
- The product is a full 2*DATA_WIDTH signed value, sign-extended to ACC_WIDTH. The sum wraps modulo 2^ACC_WIDTH; there is no saturation or overflow flag.
- issued and received are $clog2(COUNT+1) bits wide. issued saturates at COUNT.
- result is registered and equals acc. It holds stable from entry to DONE until the next start.
- res_valid = (state==DONE).

## Timing
- Reset values:
  - a_rden=0, b_rden=0, busy=0, res_valid=0, result=0.
  - state=IDLE, acc=0, counters=0, rd_pend=0.
- Cycle numbering, no stalls: start high in cycle 0.
  - busy high from cycle 1.
  - a_rden/b_rden high in cycles 1..COUNT.
  - Operands valid in cycles 2..COUNT+1.
  - res_valid first high in cycle COUNT+2.
- Each cycle in which either FIFO is empty delays completion by one cycle. rden stays low during that cycle.
- The simultaneous final read and accumulate of the prior pair are independent; both happen on the same edge.
- In DONE:
  - res_valid and result hold while res_ready=0.
  - On acceptance, busy=0 and res_valid=0 from the next cycle.
  - Earliest following start is then sampled in IDLE.
- Back-to-back results:
  - A start high during the IDLE cycle that follows acceptance begins the next run.
  - Minimum spacing between results is COUNT+3 cycles.
- Asynchronous reset mid-operation: immediate return to the reset values above. Operands already popped from the FIFOs are discarded; the FIFOs are reset independently.

## Test plan
- Reset: assert rst_n=0 mid-RUN. All outputs are 0 immediately (asynchronously). After release with start=0, the block stays in IDLE with a_rden=0.
- Basic, COUNT=4: A preloaded 1,2,3,4 and B preloaded 5,6,7,8; start in cycle 0.
  - a_rden high in cycles 1–4.
  - res_valid in cycle 6 with result=70.
- Signed: COUNT=4, A=0xFF (−1) ×4, B=0x02 ×4 → result=0xFFFFF8 (−8, ACC_WIDTH=24).
- Stall: COUNT=4, b_empty held 1 for 3 cycles after the second read.
  - a_rden=b_rden=0 during the stall; no A entries lost.
  - result=70 with res_valid in cycle 9.
- Backpressure and wrap: ACC_WIDTH=16, COUNT=4, A=B=0x80 (−128) ×4 → result=0x0000 (65536 wraps to 0).
  - Hold res_ready=0 for 5 cycles with start pulsed: res_valid and result remain stable, start is ignored.
  - After res_ready=1: busy=0 next cycle.
